// File: rtl/count_pwm_stage.sv
// PWM stage fed by a free-running up counter: duty compare, wrap detection, period counting
// and sequence checking with resynchronisation at the next wrap.
module count_pwm_stage #(
  parameter int unsigned CW  = 4,
  parameter int unsigned PCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [CW-1:0]  count,
  input  logic [CW-1:0]  duty,
  input  logic           duty_valid,
  output logic           duty_ready,
  input  logic           err_clr,
  output logic           pwm_out,
  output logic           wrap_pulse,
  output logic [PCW-1:0] period_cnt,
  output logic           seq_err,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam logic [CW-1:0]  CntMax  = {CW{1'b1}};
  localparam logic [PCW-1:0] PcntMax = {PCW{1'b1}};

  state_e         state_q;
  logic [CW-1:0]  prev_count;
  logic           prev_valid;
  logic [CW-1:0]  pending;
  logic           pending_full;
  logic [CW-1:0]  duty_active;
  logic           pwm_q;
  logic           wrap_q;
  logic [PCW-1:0] pcnt_q;
  logic           err_q;

  logic          wrap;
  logic          brk;
  logic          accept;
  logic          load;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] active_next;

  always_comb begin
    count_inc   = prev_count + CW'(1);
    wrap        = enable && prev_valid && (prev_count == CntMax) && (count == '0);
    brk         = enable && prev_valid && (count != count_inc);
    accept      = duty_valid && !pending_full;
    // Only a value already pending at the wrap is applied; a same-edge accept waits a period.
    load        = wrap && pending_full;
    active_next = load ? pending : duty_active;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      prev_count   <= '0;
      prev_valid   <= 1'b0;
      pending      <= '0;
      pending_full <= 1'b0;
      duty_active  <= '0;
      pwm_q        <= 1'b0;
      wrap_q       <= 1'b0;
      pcnt_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        pending      <= duty;
        pending_full <= 1'b1;
      end else if (load) begin
        pending_full <= 1'b0;
      end
      if (load) begin
        duty_active <= pending;
      end

      if (brk) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      if (!enable) begin
        state_q    <= StIdle;
        prev_valid <= 1'b0;
        pcnt_q     <= '0;
        pwm_q      <= 1'b0;
        wrap_q     <= 1'b0;
      end else begin
        prev_count <= count;
        prev_valid <= 1'b1;
        wrap_q     <= wrap;
        case (state_q)
          StIdle: begin
            state_q <= StArmed;
            pwm_q   <= 1'b0;
          end
          StArmed: begin
            if (wrap) begin
              state_q <= StRun;
              pwm_q   <= (count < active_next);
            end else begin
              pwm_q <= 1'b0;
            end
          end
          StRun: begin
            if (brk) begin
              state_q <= StArmed;
              pwm_q   <= 1'b0;
            end else begin
              pwm_q <= (count < active_next);
              if (wrap && (pcnt_q != PcntMax)) begin
                pcnt_q <= pcnt_q + PCW'(1);
              end
            end
          end
          default: begin
            state_q <= StIdle;
            pwm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_ready = !pending_full;
  assign pwm_out    = pwm_q;
  assign wrap_pulse = wrap_q;
  assign period_cnt = pcnt_q;
  assign seq_err    = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_count_pwm_stage.sv
// Scoreboarded bench for count_pwm_stage: directed counter streams, expected outputs queued per
// edge and popped by an independent monitor; a second instance exercises period_cnt saturation.
module tb_count_pwm_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] count;
  logic [3:0] duty;
  logic       duty_valid;
  logic       err_clr;

  logic       duty_ready, pwm_out, wrap_pulse, seq_err;
  logic [7:0] period_cnt;
  logic [1:0] state;

  logic       duty_ready2, pwm_out2, wrap_pulse2, seq_err2;
  logic [1:0] period_cnt2;
  logic [1:0] state2;

  always #5 clk = ~clk;

  count_pwm_stage #(.CW(4), .PCW(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .count(count), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .err_clr(err_clr), .pwm_out(pwm_out),
    .wrap_pulse(wrap_pulse), .period_cnt(period_cnt), .seq_err(seq_err), .state(state)
  );

  count_pwm_stage #(.CW(4), .PCW(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .count(count), .duty(duty),
    .duty_valid(duty_valid), .duty_ready(duty_ready2), .err_clr(err_clr), .pwm_out(pwm_out2),
    .wrap_pulse(wrap_pulse2), .period_cnt(period_cnt2), .seq_err(seq_err2), .state(state2)
  );

  typedef struct {
    logic [1:0] st;
    logic       pwm;
    logic       wp;
    int         pc;
    int         pc2;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Expected-behaviour state, advanced once per driven edge.
  logic [1:0] m_state;
  logic [3:0] m_prev, m_pend, m_act;
  logic       m_pv, m_pfull, m_err, m_pwm, m_wrapp;
  int         m_pcnt, m_pcnt2;
  logic       rst_next;
  logic [3:0] cnt;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_state = 2'd0; m_prev = '0; m_pend = '0; m_act = '0;
    m_pv = 1'b0; m_pfull = 1'b0; m_err = 1'b0; m_pwm = 1'b0; m_wrapp = 1'b0;
    m_pcnt = 0; m_pcnt2 = 0;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", int'(state), int'(e.st));
        check("pwm_out", int'(pwm_out), int'(e.pwm));
        check("wrap_pulse", int'(wrap_pulse), int'(e.wp));
        check("period_cnt", int'(period_cnt), e.pc);
        check("seq_err", int'(seq_err), int'(e.err));
        check("duty_ready", int'(duty_ready), int'(e.rdy));
        check("period_cnt_pcw2", int'(period_cnt2), e.pc2);
      end
    end
  end

  task automatic step(input logic [3:0] c, input logic en, input logic dv, input logic [3:0] d,
                      input logic ec);
    exp_t e;
    logic wrap, brk, acc, ld;
    @(negedge clk);
    reset = rst_next; count = c; enable = en; duty_valid = dv; duty = d; err_clr = ec;
    if (!rst_next) begin
      model_reset();
    end else begin
      wrap = en && m_pv && (m_prev == 4'd15) && (c == 4'd0);
      brk  = en && m_pv && (c != 4'(m_prev + 4'd1));
      acc  = dv && !m_pfull;
      ld   = wrap && m_pfull;
      if (brk) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
      if (ld) begin m_act = m_pend; m_pfull = 1'b0; end
      if (acc) begin m_pend = d; m_pfull = 1'b1; end
      if (!en) begin
        m_state = 2'd0; m_pv = 1'b0; m_pcnt = 0; m_pcnt2 = 0; m_pwm = 1'b0; m_wrapp = 1'b0;
      end else begin
        m_wrapp = wrap;
        if (m_state == 2'd0) m_state = 2'd1;
        else if (m_state == 2'd1) begin
          if (wrap) m_state = 2'd2;
        end else begin
          if (brk) m_state = 2'd1;
          else if (wrap) begin
            if (m_pcnt < 255) m_pcnt++;
            if (m_pcnt2 < 3) m_pcnt2++;
          end
        end
        m_pwm  = (m_state == 2'd2) && (c < m_act);
        m_prev = c;
        m_pv   = 1'b1;
      end
    end
    e.st = m_state; e.pwm = m_pwm; e.wp = m_wrapp; e.pc = m_pcnt; e.pc2 = m_pcnt2;
    e.err = m_err; e.rdy = !m_pfull;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cnt = cnt + 4'd1;
      step(cnt, 1'b1, 1'b0, 4'd0, 1'b0);
    end
  endtask

  task automatic run_to(input logic [3:0] t);
    do begin
      cnt = cnt + 4'd1;
      step(cnt, 1'b1, 1'b0, 4'd0, 1'b0);
    end while (cnt != t);
  endtask

  // Sixteen consecutive edges' pwm results, starting with the edge already driven.
  task automatic period_highs(input logic dv_last, input logic [3:0] d_last, output int h);
    h = 0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 4'd1;
      step(cnt, 1'b1, (i == 15) ? dv_last : 1'b0, d_last, 1'b0);
      h += int'(pwm_out);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_pwm_out"}, int'(pwm_out), 0);
    check({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
    check({tag, "_period_cnt"}, int'(period_cnt), 0);
    check({tag, "_seq_err"}, int'(seq_err), 0);
    check({tag, "_duty_ready"}, int'(duty_ready), 1);
    check({tag, "_state_pcw2"}, int'(state2), 0);
  endtask

  initial begin
    int h;
    reset = 1'b0; rst_next = 1'b0; enable = 1'b0; count = '0; duty = '0;
    duty_valid = 1'b0; err_clr = 1'b0; cnt = '0;
    model_reset();
    #12;
    check_reset_values("rst");
    repeat (2) step(4'd0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Startup: duty 4 offered on the first enabled edge, ARMED until the wrap.
    rst_next = 1'b1;
    cnt = 4'd10;
    step(cnt, 1'b1, 1'b1, 4'd4, 1'b0);
    run_to(4'd0);
    run(48);
    settle();
    check("pcnt_after_4_wraps", int'(period_cnt), 3);
    period_highs(1'b0, 4'd0, h);
    check("highs_duty4", h, 4);

    // Mid-period offer of 10; a second offer while not ready is dropped.
    run_to(4'd5);
    cnt = 4'd6; step(cnt, 1'b1, 1'b1, 4'd10, 1'b0);
    cnt = 4'd7; step(cnt, 1'b1, 1'b1, 4'd3, 1'b0);
    run_to(4'd0);
    period_highs(1'b0, 4'd0, h);
    check("highs_duty10", h, 10);
    settle();
    check("pcnt_total", int'(period_cnt), 6);
    check("pcnt_pcw2_saturated", int'(period_cnt2), 3);
    check("ready_after_wrap", int'(duty_ready), 1);

    // Jump 7->9 with err_clr on the same edge: set wins; later clear; resync at the wrap.
    run_to(4'd7);
    cnt = 4'd9; step(cnt, 1'b1, 1'b0, 4'd0, 1'b1);
    settle();
    check("break_seq_err", int'(seq_err), 1);
    check("break_state", int'(state), 1);
    run(2);
    cnt = 4'd12; step(cnt, 1'b1, 1'b0, 4'd0, 1'b1);
    settle();
    check("clr_seq_err", int'(seq_err), 0);
    check("clr_state_armed", int'(state), 1);
    run_to(4'd0);
    settle();
    check("resync_state", int'(state), 2);

    // Duty 0, then 15, then an offer exactly on a wrap edge with pending empty.
    run_to(4'd3);
    cnt = 4'd4; step(cnt, 1'b1, 1'b1, 4'd0, 1'b0);
    run_to(4'd0);
    period_highs(1'b0, 4'd0, h);
    check("highs_duty0", h, 0);
    run_to(4'd5);
    cnt = 4'd6; step(cnt, 1'b1, 1'b1, 4'd15, 1'b0);
    run_to(4'd0);
    period_highs(1'b1, 4'd2, h);
    check("highs_duty15", h, 15);
    period_highs(1'b0, 4'd0, h);
    check("highs_wrap_offer_deferred", h, 15);
    period_highs(1'b0, 4'd0, h);
    check("highs_duty2", h, 2);

    // Disable mid-period, then re-enable.
    run_to(4'd6);
    cnt = 4'd7; step(cnt, 1'b0, 1'b0, 4'd0, 1'b0);
    settle();
    check("dis_state", int'(state), 0);
    check("dis_pwm", int'(pwm_out), 0);
    check("dis_pcnt", int'(period_cnt), 0);
    cnt = 4'd8; step(cnt, 1'b0, 1'b0, 4'd0, 1'b0);
    cnt = 4'd9; step(cnt, 1'b0, 1'b0, 4'd0, 1'b0);
    cnt = 4'd10; step(cnt, 1'b1, 1'b0, 4'd0, 1'b0);
    run_to(4'd0);
    settle();
    check("reen_state", int'(state), 2);

    // Asynchronous reset between edges.
    run(3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    rst_next = 1'b0;
    step(cnt, 1'b1, 1'b0, 4'd0, 1'b0);
    rst_next = 1'b1;
    cnt = 4'd3; step(cnt, 1'b1, 1'b0, 4'd0, 1'b0);
    run_to(4'd0);
    run(4);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_pwm_stage.md
Name: count_pwm_stage

Overview:
- Downstream consumer of the 4-bit synchronous up counter's `count` bus.
- Compares each sampled count value against a programmable duty threshold to drive a registered PWM output.
- Detects counter wrap-around (15→0) and counts completed periods.
- Checks that the incoming sequence is a clean +1 mod 2^CW progression; on any break it resynchronises to the next wrap.

Parameters:
- CW, 4: width of the consumed count bus; period = 2^CW clocks.
- PCW, 8: width of the completed-period counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  block enable; low forces IDLE.
- count  input  CW  counter value from the upstream up counter, sampled every clock.
- duty  input  CW  requested duty threshold.
- duty_valid  input  1  duty offer valid.
- duty_ready  output  1  pending duty slot free.
- err_clr  input  1  clears sticky seq_err.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle pulse on a detected wrap.
- period_cnt  output  PCW  completed periods while in RUN, saturating.
- seq_err  output  1  sticky sequence-break flag.
- state  output  2  FSM state: 0=IDLE, 1=ARMED, 2=RUN.

Behaviour:
- Reset values: pwm_out=0, wrap_pulse=0, period_cnt=0, seq_err=0, state=IDLE, duty_ready=1. Internal state also resets: prev_count=0, prev_valid=0, pending empty, duty_active=0.
- Reset is asynchronous: assertion mid-operation clears all state immediately; the first update after deassertion occurs on the next rising edge.
- Sampling: each edge with enable=1 captures count into prev_count and sets prev_valid=1.
- Wrap: detected on the edge where prev_valid=1, prev_count=2^CW-1 and count=0. wrap_pulse is high for exactly the following cycle.
- Sequence check: on any edge with prev_valid=1 and count != (prev_count+1) mod 2^CW:
  - seq_err is set (sticky);
  - state goes to ARMED;
  - pwm_out goes to 0.
- seq_err clearing: err_clr=1 clears seq_err. If err_clr and a new break occur on the same edge, set wins.
- FSM:
  - IDLE: when enable=1, go to ARMED on the next edge.
  - ARMED: on a wrap edge, go to RUN.
  - RUN: on a sequence break, go to ARMED.
  - Any state with enable=0: go to IDLE. In IDLE, prev_valid=0, period_cnt=0, pwm_out=0; pending and duty_active are retained.
- Duty handshake:
  - Transfer occurs when duty_valid=1 and duty_ready=1 at an edge; duty is captured into pending, and duty_ready drops the cycle after.
  - On a wrap edge (ARMED→RUN or within RUN), a full pending register is copied into duty_active and pending is freed; duty_ready returns to 1 the cycle after.
  - Accept and wrap on the same edge with pending empty: the new value is stored in pending and applies at the next wrap, not the current one.
  - duty_valid while duty_ready=0 is not accepted; the offer must be held by the source.
- PWM: in RUN, pwm_out after edge = (sampled count < duty_active), evaluated with duty_active as updated by that same edge. Latency is 1 clock from count to pwm_out.
  - duty=0 gives constant 0.
  - duty=2^CW-1 gives high for 15 of 16 cycles.
  - Outside RUN, pwm_out=0.
- period_cnt: increments on each wrap edge while already in RUN (not on the ARMED→RUN wrap). It saturates at 2^PCW-1 and clears only via reset or enable=0.

Test Plan:
- Reset, enable=1, counter free-running 0..15, duty=4 loaded before the first wrap → state ARMED until the wrap, then RUN. pwm_out is high 4 cycles and low 12 per period, 1-cycle lag. wrap_pulse fires every 16 cycles; period_cnt reaches 3 after 4 wraps.
- In RUN with duty_active=4, offer duty=10 mid-period → duty_ready drops; the next period shows 10 high / 6 low; duty_ready returns to 1 the cycle after the wrap.
- Inject count jump 7→9 in RUN → seq_err=1, state=ARMED, pwm_out=0 until the next 15→0. Pulse err_clr → seq_err=0.
- duty=0 then duty=15 across periods → pwm_out constant 0, then high 15 of 16 cycles. Offer duty on the exact wrap edge with pending empty → value applies one period later.
- Drop enable mid-period → state=IDLE, pwm_out=0, period_cnt=0. Re-enable → ARMED, RUN after the next wrap. Assert reset asynchronously between edges → all outputs at reset values immediately.
- PCW=2, run 6 wraps → period_cnt saturates at 3.
